// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: state encoding, widths,
// note codes and the note-code to clock-divider mapping (C4..B5 chromatic).
package note_seq_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSE, ST_DONE} seq_state_t;

    localparam int NOTE_W = 5;
    localparam int DIV_W  = 22;

    localparam logic [DIV_W-1:0] SILENCE_DIV = 22'd1;

    localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 5'd1;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 5'd10;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 5'd13;
    localparam logic [NOTE_W-1:0] NOTE_B5   = 5'd24;

    // Each arm divides two constants, so the table folds to plain constants.
    function automatic logic [DIV_W-1:0] note_to_div(input logic [NOTE_W-1:0] code, input int clk_hz);
        int div_val;
        div_val = 0;
        case (code)
            5'd1:  div_val = clk_hz / 262;
            5'd2:  div_val = clk_hz / 277;
            5'd3:  div_val = clk_hz / 294;
            5'd4:  div_val = clk_hz / 311;
            5'd5:  div_val = clk_hz / 330;
            5'd6:  div_val = clk_hz / 349;
            5'd7:  div_val = clk_hz / 370;
            5'd8:  div_val = clk_hz / 392;
            5'd9:  div_val = clk_hz / 415;
            5'd10: div_val = clk_hz / 440;
            5'd11: div_val = clk_hz / 466;
            5'd12: div_val = clk_hz / 494;
            5'd13: div_val = clk_hz / 523;
            5'd14: div_val = clk_hz / 554;
            5'd15: div_val = clk_hz / 587;
            5'd16: div_val = clk_hz / 622;
            5'd17: div_val = clk_hz / 659;
            5'd18: div_val = clk_hz / 698;
            5'd19: div_val = clk_hz / 740;
            5'd20: div_val = clk_hz / 784;
            5'd21: div_val = clk_hz / 831;
            5'd22: div_val = clk_hz / 880;
            5'd23: div_val = clk_hz / 932;
            5'd24: div_val = clk_hz / 988;
            default: div_val = 0;
        endcase
        return (div_val == 0) ? SILENCE_DIV : DIV_W'(div_val);
    endfunction

endpackage

// File: rtl/song_rom.sv
// Fixed two-channel song table with two combinational read ports: the current
// entry and the following one (wrapping at SONG_LEN). Needs SONG_LEN >= 16.
module song_rom
    import note_seq_pkg::*;
#(
    parameter int SONG_LEN = 64,
    parameter int IDX_W    = $clog2(SONG_LEN)
) (
    input  logic [IDX_W-1:0]    addr,
    output logic [2*NOTE_W-1:0] cur_codes,
    output logic [2*NOTE_W-1:0] nxt_codes
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

    localparam logic [NOTE_W-1:0] LEFT_PAT [16] = '{
        5'd13, 5'd13, 5'd15, 5'd17, 5'd17, 5'd0,  5'd20, 5'd22,
        5'd10, 5'd10, 5'd8,  5'd6,  5'd25, 5'd25, 5'd3,  5'd24};
    localparam logic [NOTE_W-1:0] RIGHT_PAT [16] = '{
        5'd1,  5'd1,  5'd1,  5'd6,  5'd6,  5'd8,  5'd0,  5'd8,
        5'd3,  5'd3,  5'd5,  5'd30, 5'd1,  5'd1,  5'd0,  5'd1};

    // The intro (entries 0..2) is fixed; the rest repeats a 16-entry phrase.
    function automatic logic [2*NOTE_W-1:0] entry(input logic [IDX_W-1:0] a);
        logic [3:0] p;
        p = 4'(a);
        case (a)
            IDX_W'(0): entry = {NOTE_A4, NOTE_C4};
            IDX_W'(1): entry = {NOTE_A4, NOTE_REST};
            IDX_W'(2): entry = {NOTE_C5, NOTE_C4};
            default:   entry = {LEFT_PAT[p], RIGHT_PAT[p]};
        endcase
    endfunction

    logic [IDX_W-1:0] nxt_addr;

    assign nxt_addr  = (addr == IDX_LAST) ? '0 : addr + 1'b1;
    assign cur_codes = entry(addr);
    assign nxt_codes = entry(nxt_addr);

endmodule

// File: rtl/note_sequencer.sv
// Steps through the song table at BEAT_DIV cycles per beat and drives registered
// note dividers. Define NOTE_SEQ_LOOP_EN to loop the song instead of stopping in DONE.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BEAT_DIV   = 12_500_000,
    parameter int GAP_CYCLES = 500_000,
    parameter int SONG_LEN   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        play_en,
    input  logic                        restart,
    output logic [21:0]                 note_div_left,
    output logic [21:0]                 note_div_right,
    output logic [$clog2(SONG_LEN)-1:0] beat_idx,
    output logic                        playing,
    output logic                        done
);

    localparam int IDX_W = $clog2(SONG_LEN);
    localparam int CNT_W = $clog2(BEAT_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_DIV - GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SONG_LEN - 1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [NOTE_W-1:0] cur_l, cur_r, nxt_l, nxt_r;
    logic             next_valid, in_gap, gap_l, gap_r;
    logic [DIV_W-1:0] div_l_nxt, div_r_nxt;

    song_rom #(.SONG_LEN(SONG_LEN), .IDX_W(IDX_W)) u_rom (
        .addr      (beat_idx),
        .cur_codes ({cur_l, cur_r}),
        .nxt_codes ({nxt_l, nxt_r})
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= cnt_nxt;
            beat_idx <= idx_nxt;
        end
    end

    // restart outranks everything, including a beat wrap in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = beat_cnt;
        idx_nxt   = beat_idx;
        if (restart) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play_en) begin
                        state_nxt = ST_PLAY;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end
                ST_PLAY: begin
                    if (!play_en) begin
                        state_nxt = ST_PAUSE;
                    end else if (beat_cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        if (beat_idx == IDX_LAST) begin
                            idx_nxt = '0;
`ifdef NOTE_SEQ_LOOP_EN
                            state_nxt = ST_PLAY;
`else
                            state_nxt = ST_DONE;
`endif
                        end else begin
                            idx_nxt = beat_idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (play_en) state_nxt = ST_PLAY;
                end
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Without looping the last entry has no successor, so it never gets a gap.
`ifdef NOTE_SEQ_LOOP_EN
    assign next_valid = 1'b1;
`else
    assign next_valid = (beat_idx != IDX_LAST);
`endif

    always_comb begin
        in_gap    = (beat_cnt >= GAP_START);
        gap_l     = in_gap && next_valid && (nxt_l == cur_l) && (cur_l != NOTE_REST);
        gap_r     = in_gap && next_valid && (nxt_r == cur_r) && (cur_r != NOTE_REST);
        div_l_nxt = SILENCE_DIV;
        div_r_nxt = SILENCE_DIV;
        if (state == ST_PLAY) begin
            if (!gap_l) div_l_nxt = note_to_div(cur_l, CLK_HZ);
            if (!gap_r) div_r_nxt = note_to_div(cur_r, CLK_HZ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_div_left  <= SILENCE_DIV;
            note_div_right <= SILENCE_DIV;
            playing        <= 1'b0;
        end else begin
            note_div_left  <= div_l_nxt;
            note_div_right <= div_r_nxt;
            playing        <= (state == ST_PLAY);
        end
    end

`ifdef NOTE_SEQ_LOOP_EN
    assign done = 1'b0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (state == ST_DONE);
    end
`endif

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random play/restart traffic,
// checked every cycle against a beat-counting reference model of the song player.
module tb_note_sequencer;

    localparam int CLK_HZ   = 100_000_000;
    localparam int BEAT_DIV = 8;
    localparam int GAP      = 2;
    localparam int SONG_LEN = 64;
`ifdef NOTE_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    localparam int FREQ_HZ [25] = '{0, 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
                                    523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988};
    localparam int SONG_L [16] = '{13, 13, 15, 17, 17, 0, 20, 22, 10, 10, 8, 6, 25, 25, 3, 24};
    localparam int SONG_R [16] = '{1, 1, 1, 6, 6, 8, 0, 8, 3, 3, 5, 30, 1, 1, 0, 1};

    logic        clk;
    logic        rst_n;
    logic        play_en;
    logic        restart;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic [5:0]  beat_idx;
    logic        playing;
    logic        done;

    int total;
    int bad;
    int m_mode, m_idx, m_cnt;
    int exp_l, exp_r, exp_playing, exp_done;

    note_sequencer #(
        .CLK_HZ(CLK_HZ), .BEAT_DIV(BEAT_DIV), .GAP_CYCLES(GAP), .SONG_LEN(SONG_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .play_en(play_en), .restart(restart),
        .note_div_left(note_div_left), .note_div_right(note_div_right),
        .beat_idx(beat_idx), .playing(playing), .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model
    function automatic int code_at(input int idx, input int ch);
        int l, r;
        l = SONG_L[idx % 16];
        r = SONG_R[idx % 16];
        if (idx == 0) begin l = 10; r = 1; end
        if (idx == 1) begin l = 10; r = 0; end
        if (idx == 2) begin l = 13; r = 1; end
        return (ch == 0) ? l : r;
    endfunction

    function automatic int model_div(input int ch);
        int code, nidx;
        bit has_next;
        if (m_mode != M_PLAY) return 1;
        code     = code_at(m_idx, ch);
        has_next = (m_idx != SONG_LEN - 1) || LOOP;
        nidx     = (m_idx + 1) % SONG_LEN;
        if (m_cnt >= BEAT_DIV - GAP && has_next && code != 0 && code_at(nidx, ch) == code) return 1;
        if (code == 0 || code > 24) return 1;
        return CLK_HZ / FREQ_HZ[code];
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_idx  = 0;
        m_cnt  = 0;
    endtask

    // Outputs after an edge reflect the model as it stood before that edge.
    task automatic model_edge(input logic pe, input logic rs);
        exp_l       = model_div(0);
        exp_r       = model_div(1);
        exp_playing = (m_mode == M_PLAY) ? 1 : 0;
        exp_done    = (m_mode == M_DONE) ? 1 : 0;
        if (rs) begin
            model_reset();
        end else if (m_mode == M_IDLE) begin
            if (pe) begin m_mode = M_PLAY; m_idx = 0; m_cnt = 0; end
        end else if (m_mode == M_PLAY) begin
            if (!pe) m_mode = M_PAUSE;
            else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == BEAT_DIV) begin
                    m_cnt = 0;
                    m_idx = m_idx + 1;
                    if (m_idx == SONG_LEN) begin
                        m_idx = 0;
                        if (!LOOP) m_mode = M_DONE;
                    end
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (pe) m_mode = M_PLAY;
        end
    endtask

    // driver: call at a negedge; returns at the next negedge
    task automatic cycle(input logic pe, input logic rs);
        play_en = pe;
        restart = rs;
        @(posedge clk);
        model_edge(pe, rs);
        #1;
        check("div_left", 32'(note_div_left), exp_l);
        check("div_right", 32'(note_div_right), exp_r);
        check("playing", 32'(playing), exp_playing);
        check("done", 32'(done), exp_done);
        if (m_mode != M_DONE) check("beat_idx", 32'(beat_idx), m_idx);
        @(negedge clk);
    endtask

    task automatic check_silent_idle(input string tag);
        check({tag, "_left"}, 32'(note_div_left), 1);
        check({tag, "_right"}, 32'(note_div_right), 1);
        check({tag, "_playing"}, 32'(playing), 0);
        check({tag, "_idx"}, 32'(beat_idx), 0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        play_en = 1'b0;
        restart = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_silent_idle("reset");
        check("reset_done", 32'(done), 0);
        rst_n = 1'b1;

        // start playing: first note appears one cycle after PLAY entry
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("first_left", 32'(note_div_left), 227272);
        check("first_right", 32'(note_div_right), 381679);
        check("first_playing", 32'(playing), 1);

        // entry0 -> entry1: repeated A4 gets a gap on the left only
        for (int k = 2; k <= 9; k++) begin
            cycle(1'b1, 1'b0);
            if (k == 7) begin
                check("gap_left", 32'(note_div_left), 1);
                check("nogap_right", 32'(note_div_right), 381679);
            end
        end
        check("entry1_left", 32'(note_div_left), 227272);
        check("entry1_right", 32'(note_div_right), 1);

        // pause at entry2 beat_cnt 3 for 20 cycles, then resume
        for (int n = 0; n < 40 && !(m_idx == 2 && m_cnt == 3); n++) cycle(1'b1, 1'b0);
        for (int n = 0; n < 20; n++) cycle(1'b0, 1'b0);
        check("pause_left", 32'(note_div_left), 1);
        check("pause_idx", 32'(beat_idx), 2);
        cycle(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0);
        check("resume_idx_hold", 32'(beat_idx), 2);
        cycle(1'b1, 1'b0);
        check("resume_idx_next", 32'(beat_idx), 3);

        // run to the end of the song
        for (int n = 0; n < 600 && !(m_idx == SONG_LEN - 1 && m_cnt == BEAT_DIV - 1); n++)
            cycle(1'b1, 1'b0);
        check("reach_last", 32'(beat_idx), SONG_LEN - 1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        if (LOOP) begin
            check("loop_left", 32'(note_div_left), 227272);
            check("loop_playing", 32'(playing), 1);
        end else begin
            check("end_done", 32'(done), 1);
            check("end_left", 32'(note_div_left), 1);
            for (int n = 0; n < 10; n++) cycle(logic'(n % 2), 1'b0);
            check("done_hold", 32'(done), 1);
        end
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        check_silent_idle("restart");

        // restart on the same cycle as a beat wrap
        for (int n = 0; n < 30 && !(m_mode == M_PLAY && m_idx == 1 && m_cnt == BEAT_DIV - 1); n++)
            cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        check_silent_idle("restart_wrap");

        // asynchronous reset mid-beat
        for (int n = 0; n < 13; n++) cycle(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_silent_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int n = 0; n < 2500; n++)
            cycle(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 299) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream feeder of the speaker stage: steps through a fixed two-channel song table at a programmable tempo.
- Converts each 5-bit note code to a 22-bit clock-divider value on note_div_left and note_div_right.
- Provides play/pause/restart control, end-of-song detection and a re-articulation gap between repeated notes.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency used for divider constants.
- BEAT_DIV, 12_500_000, clk cycles per beat (8 beats/s).
- GAP_CYCLES, 500_000, silence cycles at the end of a beat before an identical repeated note; must be < BEAT_DIV.
- SONG_LEN, 64, number of table entries; beat_idx width = $clog2(SONG_LEN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- play_en  in  1  level; 1 = advance song, 0 = hold/pause.
- restart  in  1  single-cycle pulse; return to start.
- note_div_left  out  22  divider to speaker, left channel.
- note_div_right  out  22  divider to speaker, right channel.
- beat_idx  out  $clog2(SONG_LEN)  current table entry.
- playing  out  1  high in PLAY.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, beat_idx=0, beat_cnt=0, note_div_*=SILENCE_DIV (22'd1), playing=0, done=0.
- State machine (registered): IDLE, PLAY, PAUSE, DONE.
  - IDLE: play_en=1 -> PLAY with beat_idx=0, beat_cnt=0.
  - PLAY: beat_cnt increments each cycle.
    - At BEAT_DIV-1, beat_cnt returns to 0 and beat_idx increments.
    - If that wrap occurs at beat_idx=SONG_LEN-1 -> DONE (see Optional Feature).
    - play_en=0 -> PAUSE; beat_cnt and beat_idx frozen.
  - PAUSE: play_en=1 -> PLAY, resuming the exact beat_cnt/beat_idx.
  - DONE: holds until restart; play_en ignored.
- restart (any state) -> IDLE, beat_idx=0, beat_cnt=0 next cycle. It has priority over play_en and over a simultaneous beat wrap.
- Outputs:
  - note_div_* are registered, one-cycle latency after beat_idx/state change.
  - SILENCE_DIV in IDLE, PAUSE and DONE.
- Note mapping:
  - Code 0 = rest -> SILENCE_DIV.
  - Codes 1..24 = C4..B5 chromatic; divider = CLK_HZ / integer freq, truncated (C4=262 Hz -> 381679, A4=440 -> 227272, C5=523 -> 191204).
  - Codes 25..31 -> SILENCE_DIV.
- Gap rule, per channel independently: in PLAY, when beat_cnt >= BEAT_DIV-GAP_CYCLES, and next entry's code equals current code, and code != 0, output SILENCE_DIV.
  - "Next entry" at the last index is entry 0 when looping; otherwise no gap.
- playing/done are registered decodes of state.

Optional Feature:
- NOTE_SEQ_LOOP_EN defined: the wrap at beat_idx=SONG_LEN-1 returns to beat_idx=0, staying in PLAY; DONE is unreachable and done is tied 0.
- Not defined: the wrap enters DONE as described above.

Decomposition:
- Package note_seq_pkg:
  - state enum.
  - NOTE_W=5 and DIV_W=22.
  - SILENCE_DIV.
  - note-code localparams.
  - Function note_to_div(code, CLK_HZ) holding the 24-entry frequency table.
- Sub-module song_rom:
  - Combinational, two read ports (addr, addr+1 mod SONG_LEN), each returning {code_left, code_right}.
  - Fixed contents: entry0 L=10 R=1, entry1 L=10 R=0, entry2 L=13 R=1; remaining entries are the song.

Test Plan (BEAT_DIV=8, GAP_CYCLES=2, SONG_LEN=64):
- Reset then play_en=1 -> cycle after PLAY entry: note_div_left=227272, note_div_right=381679, playing=1.
- Entry0->entry1 with left A4 repeated -> left=1 at beat_cnt 6..7, then 227272 after the wrap; right=381679 for the whole beat with no gap (entry1 R=rest), then 1 in entry1.
- play_en=0 at beat_cnt=3 of entry2 for 20 cycles -> outputs 1, beat_idx=2 held; on resume, 5 more cycles until beat_idx=3.
- Run to beat_idx=63 wrap, macro undefined -> state DONE, done=1, outputs 1; play_en toggling has no effect; restart -> IDLE, beat_idx=0.
- Same run with NOTE_SEQ_LOOP_EN -> beat_idx wraps 63->0, playing stays 1, left=227272 one cycle later.
- restart asserted in the same cycle as a beat wrap in PLAY; separately, rst_n pulsed low mid-beat -> both give beat_idx=0, outputs 1, playing=0.
